// File: rtl/lcd_power_seq.sv
// ============================================================================
//  Module   : lcd_power_seq
//  Purpose  : Panel power/enable sequencer (DISP, timing-gen enable, backlight)
//             Optional macro LCD_POWER_SEQ_BL_RAMP_EN ramps backlight duty.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_power_seq #(
    parameter logic [15:0] T_PWR_ON      = 16'd1000,
    parameter logic [7:0]  FRAMES_BL_ON  = 8'd4,
    parameter logic [7:0]  FRAMES_BL_OFF = 8'd2,
    parameter logic [15:0] T_PWR_OFF     = 16'd1000,
    parameter logic [23:0] VS_TIMEOUT    = 24'd2000000
) (
    input  logic       vga_clk,
    input  logic       rst,
    input  logic       panel_en,
    input  logic       vga_vs,
    input  logic [7:0] bl_duty,
    output logic       tg_en,
    output logic       vpg_disp,
    output logic       bl_en,
    output logic       bl_pwm,
    output logic       ready,
    output logic       vs_timeout,
    output logic [2:0] seq_state
);

    localparam logic [2:0] c_st_off        = 3'd0;
    localparam logic [2:0] c_st_pwr_wait   = 3'd1;
    localparam logic [2:0] c_st_frame_wait = 3'd2;
    localparam logic [2:0] c_st_on         = 3'd3;
    localparam logic [2:0] c_st_bl_off     = 3'd4;
    localparam logic [2:0] c_st_disp_off   = 3'd5;

    localparam logic [23:0] c_pwr_on_last  = 24'(T_PWR_ON) - 24'd1;
    localparam logic [23:0] c_pwr_off_last = 24'(T_PWR_OFF) - 24'd1;
    localparam logic [23:0] c_timeout_last = VS_TIMEOUT - 24'd1;
    localparam logic [7:0]  c_bl_on_last   = FRAMES_BL_ON - 8'd1;
    localparam logic [7:0]  c_bl_off_last  = FRAMES_BL_OFF - 8'd1;

    logic [2:0]  state_q, state_d;
    logic        vs_prev_q;
    logic [23:0] cyc_q;
    logic [7:0]  frm_q;
    logic        timeout_q, timeout_hit_d;
    logic        tg_en_q, disp_q, bl_en_q, ready_q, bl_pwm_q;
    logic        tg_en_d, disp_d, bl_en_d, ready_d;
    logic [7:0]  pwm_cnt_q;
    logic [7:0]  w_duty_eff;
    logic        w_vs_fall;

    assign w_vs_fall = vs_prev_q & ~vga_vs;

    // panel_en is checked first in the power-up states so an abort always wins
    always_comb begin
        state_d       = state_q;
        timeout_hit_d = 1'b0;
        case (state_q)
            c_st_off: begin
                if (panel_en) state_d = c_st_pwr_wait;
            end
            c_st_pwr_wait: begin
                if (!panel_en)                   state_d = c_st_disp_off;
                else if (cyc_q == c_pwr_on_last) state_d = c_st_frame_wait;
            end
            c_st_frame_wait: begin
                if (!panel_en) begin
                    state_d = c_st_disp_off;
                end else if (w_vs_fall && (frm_q == c_bl_on_last)) begin
                    state_d = c_st_on;
                end else if (cyc_q == c_timeout_last) begin
                    state_d       = c_st_on;
                    timeout_hit_d = 1'b1;
                end
            end
            c_st_on: begin
                if (!panel_en) state_d = c_st_bl_off;
            end
            c_st_bl_off: begin
                if (w_vs_fall && (frm_q == c_bl_off_last)) begin
                    state_d = c_st_disp_off;
                end else if (cyc_q == c_timeout_last) begin
                    state_d       = c_st_disp_off;
                    timeout_hit_d = 1'b1;
                end
            end
            c_st_disp_off: begin
                if (cyc_q == c_pwr_off_last) state_d = c_st_off;
            end
            default: state_d = c_st_off;
        endcase
    end

    // Moore outputs decoded from the next state so they register with it
    always_comb begin
        disp_d  = 1'b0;
        tg_en_d = 1'b0;
        bl_en_d = 1'b0;
        ready_d = 1'b0;
        case (state_d)
            c_st_pwr_wait:   disp_d = 1'b1;
            c_st_frame_wait: begin disp_d = 1'b1; tg_en_d = 1'b1; end
            c_st_on: begin
                disp_d  = 1'b1;
                tg_en_d = 1'b1;
                bl_en_d = 1'b1;
                ready_d = 1'b1;
            end
            c_st_bl_off:     begin disp_d = 1'b1; tg_en_d = 1'b1; end
            c_st_disp_off:   disp_d = 1'b1;
            default:         disp_d = 1'b0;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            state_q   <= c_st_off;
            vs_prev_q <= 1'b1;
            cyc_q     <= 24'd0;
            frm_q     <= 8'd0;
            timeout_q <= 1'b0;
            disp_q    <= 1'b0;
            tg_en_q   <= 1'b0;
            bl_en_q   <= 1'b0;
            ready_q   <= 1'b0;
            pwm_cnt_q <= 8'd0;
            bl_pwm_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            vs_prev_q <= vga_vs;
            if (state_d != state_q) begin
                cyc_q <= 24'd0;
                frm_q <= 8'd0;
            end else begin
                cyc_q <= cyc_q + 24'd1;
                frm_q <= frm_q + {7'd0, w_vs_fall};
            end
            timeout_q <= timeout_q | timeout_hit_d;
            disp_q    <= disp_d;
            tg_en_q   <= tg_en_d;
            bl_en_q   <= bl_en_d;
            ready_q   <= ready_d;
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
            bl_pwm_q  <= bl_en_q & (pwm_cnt_q < w_duty_eff);
        end
    end

`ifdef LCD_POWER_SEQ_BL_RAMP_EN
    logic [7:0] duty_ramp_q;

    // Soft-start: one duty step per frame, but a lowered target applies at once
    always_ff @(posedge vga_clk) begin
        if (rst || (state_q != c_st_on)) begin
            duty_ramp_q <= 8'd0;
        end else if (bl_duty < duty_ramp_q) begin
            duty_ramp_q <= bl_duty;
        end else if (w_vs_fall && (duty_ramp_q != bl_duty)) begin
            duty_ramp_q <= duty_ramp_q + 8'd1;
        end
    end

    assign w_duty_eff = duty_ramp_q;
`else
    assign w_duty_eff = bl_duty;
`endif

    assign tg_en      = tg_en_q;
    assign vpg_disp   = disp_q;
    assign bl_en      = bl_en_q;
    assign bl_pwm     = bl_pwm_q;
    assign ready      = ready_q;
    assign vs_timeout = timeout_q;
    assign seq_state  = state_q;

endmodule

`default_nettype wire
